lrsc_reservation_station: RTL and testbench
===========================================

// Module: lrsc_reservation_station
// PURPOSE
// - Consumer of the decoder's LR/SC controls (res_station_valid, store_cond, MemWr) for the multi-hart core.
// - Keeps one address reservation per hart and resolves each SC as success or failure.
// - Gates the SC memory write and returns the RISC-V SC result word for writeback select 2'b11.
// - Sits beside the data-memory port; sees every memory op issued, at most one op per cycle.
// PARAMETERS
// - NUM_HARTS     16  number of hardware threads; one reservation entry each
// - HART_ID_W     4   width of hart id; must equal $clog2(NUM_HARTS)
// - ADDR_W        32  byte-address width
// - GRANULE_LSB   2   reservation granule is 2**GRANULE_LSB bytes; addr[ADDR_W-1:GRANULE_LSB] compared
// - TIMEOUT_CYC   64  reservation lifetime in cycles; used only with RSV_TIMEOUT_EN
// PORTS
// - i_clk                 in   1          clock; all state on rising edge
// - i_rstn                in   1          asynchronous active-low reset
// - i_valid               in   1          memory-stage op valid this cycle
// - i_hart_id             in   HART_ID_W  issuing hart
// - i_addr                in   ADDR_W     effective address from ALU
// - i_res_station_valid   in   1          LR.W in flight
// - i_store_cond          in   1          SC.W in flight
// - i_MemWr               in   1          ordinary store in flight
// - o_sc_mem_wr           out  1          combinational write enable for a successful SC, same cycle
// - o_sc_result_valid     out  1          registered; SC result present, 1 cycle after SC
// - o_sc_result           out  32         registered; 32'd0 = success, 32'd1 = failure
// - o_rsv_valid           out  NUM_HARTS  registered per-hart reservation-held flags
// BEHAVIOUR
// - Per-hart state, two states:
//   - EMPTY -> RESERVED on LR.
//   - RESERVED -> EMPTY on own SC, on kill, or on expiry.
// - Entry storage: {valid, tag = addr[ADDR_W-1:GRANULE_LSB]}.
// - Reset (async, i_rstn=0): all entries EMPTY; o_rsv_valid=0; o_sc_result_valid=0; o_sc_result=0; o_sc_mem_wr=0.
// - Ops are ignored when i_valid=0.
// - Priority when more than one op strobe is high: SC > LR > store.
// - LR: entry[hart] <= {1, tag}. Overwrites any earlier reservation held by that hart. No output response.
// - SC:
//   - success = entry[hart].valid && entry[hart].tag == tag.
//   - o_sc_mem_wr = success (combinational, same cycle).
//   - Next cycle: o_sc_result_valid=1 and o_sc_result={31'b0, ~success}.
//   - entry[hart] is cleared whether the SC succeeds or fails.
// - Kill: a store that writes memory (i_MemWr, or an SC with success) clears every entry whose tag matches, the writer's own entry included.
// - Same-edge LR and kill: an LR on hart h in the cycle of a matching kill leaves entry[h] valid (the new reservation wins). Other harts' matching entries are still cleared.
// - o_sc_result_valid is a 1-cycle pulse. Back-to-back SCs give back-to-back pulses with no bubble.
// - Reset mid-operation discards all reservations. An SC in the same cycle as reset produces no result pulse.
// - o_rsv_valid[h] mirrors entry[h].valid.
// CONFIGURATION
// - RSV_TIMEOUT_EN defined:
//   - Each hart has a counter, loaded with TIMEOUT_CYC-1 on LR and decremented every cycle while RESERVED.
//   - At 0 the entry goes EMPTY on the next edge, so an SC issued exactly TIMEOUT_CYC cycles after the LR fails.
//   - A fresh LR reloads the counter.
// - RSV_TIMEOUT_EN undefined: no counters; a reservation lives until SC, kill or reset.
// TESTING
// - Reset: release i_rstn -> o_rsv_valid=0, o_sc_result_valid=0, o_sc_result=0.
// - Basic LR/SC: hart 3 LR 0x1000, then hart 3 SC 0x1000 -> o_sc_mem_wr=1 that cycle; next cycle o_sc_result=0 with valid; o_rsv_valid[3]=0.
// - SC without a reservation: hart 5 SC 0x2000 -> o_sc_mem_wr=0; o_sc_result=1.
// - Cross-hart kill: harts 1 and 2 LR 0x3000; hart 7 stores 0x3002 (same granule) -> both entries cleared; hart 1 SC 0x3000 then fails with result 1.
// - Different granule and simultaneous events:
//   - A store to 0x3004 does not clear a 0x3000 reservation.
//   - LR and a matching kill on the same edge leave the LR hart's entry valid.
// - Timeout (RSV_TIMEOUT_EN, TIMEOUT_CYC=4): LR at cycle 0.
//   - SC at cycle 3 -> result 0.
//   - Repeat with SC at cycle 4 -> result 1.

Source files
------------

// File: rtl/lrsc_reservation_station.sv
// lrsc_reservation_station: per-hart LR/SC reservations, SC write gating and SC result word; RSV_TIMEOUT_EN adds reservation expiry
module lrsc_reservation_station #(
   parameter int NUM_HARTS   = 16,
   parameter int HART_ID_W   = 4,
   parameter int ADDR_W      = 32,
   parameter int GRANULE_LSB = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_valid,
   input  logic [HART_ID_W-1:0] i_hart_id,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic                 i_res_station_valid,
   input  logic                 i_store_cond,
   input  logic                 i_MemWr,
   output logic                 o_sc_mem_wr,
   output logic                 o_sc_result_valid,
   output logic [31:0]          o_sc_result,
   output logic [NUM_HARTS-1:0] o_rsv_valid
);
   localparam int TAG_W = ADDR_W - GRANULE_LSB;
   logic [NUM_HARTS-1:0] valid, live;
   logic [TAG_W-1:0]     tags [NUM_HARTS];
   logic [TAG_W-1:0]     tag;
   logic                 is_sc, is_lr, is_st, success, kill;
   logic                 unused_low;
   assign tag         = i_addr[ADDR_W-1:GRANULE_LSB];
   assign unused_low  = ^i_addr[GRANULE_LSB-1:0];
   assign is_sc       = i_valid & i_store_cond;
   assign is_lr       = i_valid & ~i_store_cond & i_res_station_valid;
   assign is_st       = i_valid & ~i_store_cond & ~i_res_station_valid & i_MemWr;
   assign success     = is_sc & live[i_hart_id] & (tags[i_hart_id] == tag);
   assign kill        = is_st | success;
   assign o_sc_mem_wr = success;
   assign o_rsv_valid = valid;
`ifdef RSV_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] cnt [NUM_HARTS];
   // an entry whose countdown reached zero no longer satisfies an SC and is dropped at the next edge
   always_comb
      for (int h = 0; h < NUM_HARTS; h++) live[h] = valid[h] && (cnt[h] != '0);
   // countdown reloads on every LR and runs down while the entry is held
   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn)
         for (int h = 0; h < NUM_HARTS; h++) cnt[h] <= '0;
      else
         for (int h = 0; h < NUM_HARTS; h++)
            if (is_lr && i_hart_id == HART_ID_W'(h)) cnt[h] <= CNT_W'(TIMEOUT_CYC - 1);
            else if (live[h]) cnt[h] <= cnt[h] - 1'b1;
`else
   localparam int unused_timeout = TIMEOUT_CYC;
   assign live = valid;
`endif
   // own LR always wins its slot; own SC, a matching kill or expiry empties it
   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn)
         valid <= '0;
      else
         for (int h = 0; h < NUM_HARTS; h++)
            valid[h] <= (is_lr && i_hart_id == HART_ID_W'(h)) ||
                        (live[h] && !(is_sc && i_hart_id == HART_ID_W'(h)) && !(kill && tags[h] == tag));
   // reservation tag is captured on LR; it is only meaningful while the entry is valid
   always_ff @(posedge i_clk)
      if (is_lr) tags[i_hart_id] <= tag;
   // one-cycle result pulse per SC; result word is 0 on success, 1 on failure
   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) begin
         o_sc_result_valid <= 1'b0;
         o_sc_result       <= '0;
      end else begin
         o_sc_result_valid <= is_sc;
         if (is_sc) o_sc_result <= {31'b0, ~success};
      end
endmodule

// File: tb/tb_lrsc_reservation_station.sv
// tb_lrsc_reservation_station: directed and randomized checks of LR/SC reservations against a reservation-table model; RSV_TIMEOUT_EN adds expiry tests
module tb_lrsc_reservation_station;
   localparam int TO = 4;
   logic        i_clk = 1'b0, i_rstn = 1'b0, i_valid = 1'b0;
   logic [3:0]  i_hart_id = '0;
   logic [31:0] i_addr = '0;
   logic        i_res_station_valid = 1'b0, i_store_cond = 1'b0, i_MemWr = 1'b0;
   logic        o_sc_mem_wr, o_sc_result_valid;
   logic [31:0] o_sc_result;
   logic [15:0] o_rsv_valid;
   int compared = 0, mismatched = 0;
   bit          m_valid [16];
   int unsigned m_gran [16];
   int          m_age [16];
   logic        exp_wr, act_wr, exp_rv, act_rv;
   logic [31:0] exp_res = '0, act_res;
   logic [15:0] exp_rsv, act_rsv;

   lrsc_reservation_station #(.TIMEOUT_CYC(TO)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_hart_id(i_hart_id), .i_addr(i_addr),
      .i_res_station_valid(i_res_station_valid), .i_store_cond(i_store_cond), .i_MemWr(i_MemWr),
      .o_sc_mem_wr(o_sc_mem_wr), .o_sc_result_valid(o_sc_result_valid), .o_sc_result(o_sc_result),
      .o_rsv_valid(o_rsv_valid));

   always #5 i_clk = ~i_clk;

   task automatic model_reset();
      for (int k = 0; k < 16; k++) begin
         m_valid[k] = 1'b0;
         m_age[k]   = 0;
      end
      exp_res = '0;
   endtask

   // drive one op from a negedge, sample the same-cycle write enable, then the registered outputs at the next negedge
   task automatic apply(input bit v, input int h, input logic [31:0] a, input bit lr, input bit sc, input bit st);
      bit is_sc, is_lr, is_st, succ;
      int unsigned g;
      g     = a >> 2;
      is_sc = v && sc;
      is_lr = v && lr && !sc;
      is_st = v && st && !sc && !lr;
`ifdef RSV_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         m_age[k]++;
         if (m_age[k] >= TO) m_valid[k] = 1'b0;
      end
`endif
      succ = is_sc && m_valid[h] && m_gran[h] == g;
      i_valid = v; i_hart_id = 4'(h); i_addr = a;
      i_res_station_valid = lr; i_store_cond = sc; i_MemWr = st;
      #1;
      exp_wr = succ;
      act_wr = o_sc_mem_wr;
      @(posedge i_clk);
      if (is_st || succ)
         for (int k = 0; k < 16; k++) if (m_valid[k] && m_gran[k] == g) m_valid[k] = 1'b0;
      if (is_sc) m_valid[h] = 1'b0;
      if (is_lr) begin
         m_valid[h] = 1'b1;
         m_gran[h]  = g;
         m_age[h]   = 0;
      end
      exp_rv = is_sc;
      if (is_sc) exp_res = succ ? 32'd0 : 32'd1;
      for (int k = 0; k < 16; k++) exp_rsv[k] = m_valid[k];
      @(negedge i_clk);
      act_rv  = o_sc_result_valid;
      act_res = o_sc_result;
      act_rsv = o_rsv_valid;
      i_valid = 1'b0; i_res_station_valid = 1'b0; i_store_cond = 1'b0; i_MemWr = 1'b0;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      model_reset();
      repeat (2) @(negedge i_clk);
      compared += 4;
      if (o_rsv_valid !== 16'h0) begin mismatched++; $display("FAIL reset_rsv: got %h expected 0000", o_rsv_valid); end
      if (o_sc_result_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rv: got %b expected 0", o_sc_result_valid); end
      if (o_sc_result !== 32'd0) begin mismatched++; $display("FAIL reset_res: got %h expected 0", o_sc_result); end
      if (o_sc_mem_wr !== 1'b0) begin mismatched++; $display("FAIL reset_wr: got %b expected 0", o_sc_mem_wr); end
      i_rstn = 1'b1;
      @(negedge i_clk);
      compared += 2;
      if (o_rsv_valid !== 16'h0) begin mismatched++; $display("FAIL release_rsv: got %h expected 0000", o_rsv_valid); end
      if (o_sc_result_valid !== 1'b0) begin mismatched++; $display("FAIL release_rv: got %b expected 0", o_sc_result_valid); end
   endtask

   task automatic test_basic_lr_sc();
      apply(1, 3, 32'h1000, 1, 0, 0);
      compared += 2;
      if (act_rsv[3] !== 1'b1) begin mismatched++; $display("FAIL basic_lr_rsv: got %b expected 1", act_rsv[3]); end
      if (act_rv !== 1'b0) begin mismatched++; $display("FAIL basic_lr_rv: got %b expected 0", act_rv); end
      apply(1, 3, 32'h1000, 0, 1, 0);
      compared += 4;
      if (act_wr !== 1'b1) begin mismatched++; $display("FAIL basic_sc_wr: got %b expected 1", act_wr); end
      if (act_rv !== 1'b1) begin mismatched++; $display("FAIL basic_sc_rv: got %b expected 1", act_rv); end
      if (act_res !== 32'd0) begin mismatched++; $display("FAIL basic_sc_res: got %h expected 0", act_res); end
      if (act_rsv[3] !== 1'b0) begin mismatched++; $display("FAIL basic_sc_rsv: got %b expected 0", act_rsv[3]); end
      @(negedge i_clk);
      compared++;
      if (o_sc_result_valid !== 1'b0) begin mismatched++; $display("FAIL basic_pulse_len: got %b expected 0", o_sc_result_valid); end
   endtask

   task automatic test_sc_no_rsv();
      apply(1, 5, 32'h2000, 0, 1, 0);
      compared += 3;
      if (act_wr !== 1'b0) begin mismatched++; $display("FAIL norsv_wr: got %b expected 0", act_wr); end
      if (act_rv !== 1'b1) begin mismatched++; $display("FAIL norsv_rv: got %b expected 1", act_rv); end
      if (act_res !== 32'd1) begin mismatched++; $display("FAIL norsv_res: got %h expected 1", act_res); end
   endtask

   task automatic test_cross_kill();
      apply(1, 1, 32'h3000, 1, 0, 0);
      apply(1, 2, 32'h3000, 1, 0, 0);
      compared++;
      if (act_rsv[2:1] !== 2'b11) begin mismatched++; $display("FAIL kill_setup: got %b expected 11", act_rsv[2:1]); end
      apply(1, 7, 32'h3002, 0, 0, 1);
      compared++;
      if (act_rsv[2:1] !== 2'b00) begin mismatched++; $display("FAIL kill_clear: got %b expected 00", act_rsv[2:1]); end
      apply(1, 1, 32'h3000, 0, 1, 0);
      compared += 2;
      if (act_wr !== 1'b0) begin mismatched++; $display("FAIL kill_sc_wr: got %b expected 0", act_wr); end
      if (act_res !== 32'd1) begin mismatched++; $display("FAIL kill_sc_res: got %h expected 1", act_res); end
   endtask

   task automatic test_granule_and_sc_kill();
      apply(1, 4, 32'h3000, 1, 0, 0);
      apply(1, 7, 32'h3004, 0, 0, 1);
      compared++;
      if (act_rsv[4] !== 1'b1) begin mismatched++; $display("FAIL granule_keep: got %b expected 1", act_rsv[4]); end
      apply(1, 0, 32'h5000, 1, 0, 0);
      apply(1, 8, 32'h5001, 1, 0, 0);
      apply(1, 0, 32'h5000, 0, 1, 0);
      compared += 3;
      if (act_wr !== 1'b1) begin mismatched++; $display("FAIL sckill_wr: got %b expected 1", act_wr); end
      if (act_rsv[8] !== 1'b0) begin mismatched++; $display("FAIL sckill_other: got %b expected 0", act_rsv[8]); end
      if (act_rsv[4] !== 1'b1) begin mismatched++; $display("FAIL sckill_unrelated: got %b expected 1", act_rsv[4]); end
      apply(1, 6, 32'h5000, 1, 0, 1);
      compared += 2;
      if (act_rsv[6] !== 1'b1) begin mismatched++; $display("FAIL lr_prio_rsv: got %b expected 1", act_rsv[6]); end
      if (act_rv !== 1'b0) begin mismatched++; $display("FAIL lr_prio_rv: got %b expected 0", act_rv); end
   endtask

   task automatic test_back_to_back();
      apply(1, 9, 32'h6000, 1, 0, 0);
      apply(1, 10, 32'h7000, 1, 0, 0);
      apply(1, 9, 32'h6000, 0, 1, 0);
      compared += 2;
      if (act_rv !== 1'b1) begin mismatched++; $display("FAIL b2b_rv0: got %b expected 1", act_rv); end
      if (act_res !== 32'd0) begin mismatched++; $display("FAIL b2b_res0: got %h expected 0", act_res); end
      apply(1, 10, 32'h7000, 0, 1, 0);
      compared += 2;
      if (act_rv !== 1'b1) begin mismatched++; $display("FAIL b2b_rv1: got %b expected 1", act_rv); end
      if (act_res !== 32'd0) begin mismatched++; $display("FAIL b2b_res1: got %h expected 0", act_res); end
      apply(1, 10, 32'h7000, 0, 1, 0);
      compared += 2;
      if (act_rv !== 1'b1) begin mismatched++; $display("FAIL b2b_rv2: got %b expected 1", act_rv); end
      if (act_res !== 32'd1) begin mismatched++; $display("FAIL b2b_res2: got %h expected 1", act_res); end
   endtask

   task automatic test_reset_midop();
      apply(1, 2, 32'h4000, 1, 0, 0);
      i_valid = 1'b1; i_hart_id = 4'd2; i_addr = 32'h4000; i_store_cond = 1'b1;
      i_rstn = 1'b0;
      #1;
      compared++;
      if (o_sc_mem_wr !== 1'b0) begin mismatched++; $display("FAIL midrst_wr: got %b expected 0", o_sc_mem_wr); end
      @(posedge i_clk);
      @(negedge i_clk);
      compared += 2;
      if (o_sc_result_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_rv: got %b expected 0", o_sc_result_valid); end
      if (o_rsv_valid !== 16'h0) begin mismatched++; $display("FAIL midrst_rsv: got %h expected 0000", o_rsv_valid); end
      i_valid = 1'b0; i_store_cond = 1'b0;
      i_rstn = 1'b1;
      model_reset();
      apply(1, 2, 32'h4000, 0, 1, 0);
      compared += 2;
      if (act_wr !== 1'b0) begin mismatched++; $display("FAIL midrst_sc_wr: got %b expected 0", act_wr); end
      if (act_res !== 32'd1) begin mismatched++; $display("FAIL midrst_sc_res: got %h expected 1", act_res); end
   endtask

`ifdef RSV_TIMEOUT_EN
   task automatic test_timeout();
      apply(1, 3, 32'h1000, 1, 0, 0);
      repeat (2) apply(0, 0, 32'h0, 0, 0, 0);
      apply(1, 3, 32'h1000, 0, 1, 0);
      compared += 2;
      if (act_wr !== 1'b1) begin mismatched++; $display("FAIL to3_wr: got %b expected 1", act_wr); end
      if (act_res !== 32'd0) begin mismatched++; $display("FAIL to3_res: got %h expected 0", act_res); end
      apply(1, 3, 32'h1000, 1, 0, 0);
      repeat (3) apply(0, 0, 32'h0, 0, 0, 0);
      apply(1, 3, 32'h1000, 0, 1, 0);
      compared += 2;
      if (act_wr !== 1'b0) begin mismatched++; $display("FAIL to4_wr: got %b expected 0", act_wr); end
      if (act_res !== 32'd1) begin mismatched++; $display("FAIL to4_res: got %h expected 1", act_res); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] pool [6] = '{32'h3000, 32'h3002, 32'h3004, 32'h1000, 32'h1003, 32'h8000};
      int h, r;
      bit v, lr, sc, st;
      for (int n = 0; n < 600; n++) begin
         h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
         v  = $urandom_range(0, 7) != 0;
         r  = $urandom_range(0, 5);
         lr = (r <= 1) || (r == 5);
         sc = (r == 2) || (r == 3) || (r == 5);
         st = (r == 4) || (r == 5);
         apply(v, h, pool[$urandom_range(0, 5)], lr, sc, st);
         compared += 3;
         if (act_wr !== exp_wr) begin mismatched++; $display("FAIL rand_wr[%0d]: got %b expected %b", n, act_wr, exp_wr); end
         if (act_rv !== exp_rv) begin mismatched++; $display("FAIL rand_rv[%0d]: got %b expected %b", n, act_rv, exp_rv); end
         if (act_rsv !== exp_rsv) begin mismatched++; $display("FAIL rand_rsv[%0d]: got %h expected %h", n, act_rsv, exp_rsv); end
         if (exp_rv) begin
            compared++;
            if (act_res !== exp_res) begin mismatched++; $display("FAIL rand_res[%0d]: got %h expected %h", n, act_res, exp_res); end
         end
      end
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_basic_lr_sc();
      test_sc_no_rsv();
      test_cross_kill();
      test_granule_and_sc_kill();
      test_back_to_back();
      test_reset_midop();
`ifdef RSV_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
